// File: rtl/obfus_block_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : obfus_block_scheduler
//  Purpose  : Splits a plaintext block into NWORDS words, drives the
//             Fibonacci random encoder one word at a time and packs the
//             returned codewords into a single output block.
//  Options  : SCHED_TIMEOUT_EN - per-word watchdog with sticky err flag and
//             all-ones codeword substitution when the encoder hangs.
//  Revision : 1.0 - initial release
// ============================================================================
module obfus_block_scheduler #(
    parameter int NWORDS         = 2,
    parameter int WORD_W         = 64,
    parameter int CODE_W         = 128,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NWORDS*WORD_W-1:0] in_data,
    output logic                     enc_en,
    output logic [WORD_W-1:0]        enc_data,
    input  logic                     enc_done,
    input  logic [CODE_W-1:0]        enc_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NWORDS*CODE_W-1:0] out_data,
    output logic                     busy,
    output logic                     err
);

    localparam int c_idx_w = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NWORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_NEXT      = 3'd4,
        S_OUTPUT    = 3'd5
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [NWORDS*WORD_W-1:0]   r_block;
    logic [NWORDS*CODE_W-1:0]   r_slots;
    logic [c_idx_w-1:0]         r_idx;
    logic                       r_enc_en;
    logic [WORD_W-1:0]          r_enc_data;
    logic                       w_capture;
    logic                       w_timeout;
    logic                       w_wd_hit;
    logic [WORD_W-1:0]          w_word;

    assign w_word   = r_block[int'(r_idx)*WORD_W +: WORD_W];
    assign enc_en   = r_enc_en;
    assign enc_data = r_enc_data;
    assign out_data = r_slots;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake/status outputs
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            // A done level left over from the previous word must fall
            // before a new enable, otherwise it would look like a result.
            S_ISSUE: begin
                w_state_nxt = enc_done ? S_WAIT_LOW : S_WAIT_DONE;
            end
            S_WAIT_LOW: begin
                if (!enc_done) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            // Only the first done cycle is used; leaving the state makes
            // the capture edge-qualified.
            S_WAIT_DONE: begin
                if (enc_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_NEXT;
                end else if (w_wd_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                w_state_nxt = (r_idx == c_last_idx) ? S_OUTPUT : S_ISSUE;
            end
            S_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Block capture, word issue, codeword packing and word index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_block    <= '0;
            r_slots    <= '0;
            r_idx      <= '0;
            r_enc_en   <= 1'b0;
            r_enc_data <= '0;
        end else begin
            r_enc_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_block <= in_data;
                        r_idx   <= '0;
                    end
                end
                S_ISSUE: begin
                    r_enc_data <= w_word;
                    r_enc_en   <= ~enc_done;
                end
                S_WAIT_DONE: begin
                    if (w_capture) begin
                        r_slots[int'(r_idx)*CODE_W +: CODE_W] <= enc_result;
                    end else if (w_timeout) begin
                        r_slots[int'(r_idx)*CODE_W +: CODE_W] <= '1;
                    end
                end
                S_NEXT: begin
                    if (r_idx != c_last_idx) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SCHED_TIMEOUT_EN
    localparam logic [12:0] c_wdog_max = 13'(TIMEOUT_CYCLES - 1);

    logic [12:0] r_wdog;
    logic        r_err;

    // Per-word watchdog: cleared when a word is issued, counts WAIT_DONE cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_wdog <= '0;
            end else if (r_state == S_WAIT_DONE) begin
                r_wdog <= r_wdog + 13'd1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_wd_hit = (r_wdog == c_wdog_max);
    assign err      = r_err;
`else
    assign w_wd_hit = 1'b0;
    assign err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_obfus_block_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_obfus_block_scheduler
//  Purpose  : Self-checking bench for obfus_block_scheduler with a
//             behavioural encoder model and an output scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_obfus_block_scheduler;

    localparam int NW = 2;
    localparam int WW = 64;
    localparam int CW = 128;
`ifdef SCHED_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 4096;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [NW*WW-1:0]  in_data;
    logic              enc_en;
    logic [WW-1:0]     enc_data;
    logic              enc_done;
    logic [CW-1:0]     enc_result;
    logic              out_valid;
    logic              out_ready;
    logic [NW*CW-1:0]  out_data;
    logic              busy;
    logic              err;

    obfus_block_scheduler #(
        .NWORDS(NW), .WORD_W(WW), .CODE_W(CW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .enc_en(enc_en), .enc_data(enc_data),
        .enc_done(enc_done), .enc_result(enc_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [NW*CW-1:0] exp_out_q[$];
    logic [WW-1:0]    exp_iss_q[$];

    // encoder model controls
    int          m_dly  = 10;
    int          m_hold = 1;
    bit          m_hang = 1'b0;
    int          m_cnt  = 0;
    int          m_hcnt = 0;
    int          en_count = 0;
    logic [WW-1:0] m_data;

    function automatic logic [CW-1:0] enc_f(input logic [WW-1:0] w);
        return {w ^ 64'hDEAD_BEEF_CAFE_F00D, ~w};
    endfunction

    function automatic logic [NW*CW-1:0] pack_exp(input logic [NW*WW-1:0] d);
        logic [NW*CW-1:0] r;
        for (int i = 0; i < NW; i++) r[i*CW +: CW] = enc_f(d[i*WW +: WW]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [NW*CW-1:0] act, input logic [NW*CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Encoder model: samples word on enable, raises done after m_dly cycles for m_hold cycles
    initial begin
        enc_done   = 1'b0;
        enc_result = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                enc_done   = 1'b0;
                enc_result = '0;
                m_cnt      = 0;
                m_hcnt     = 0;
            end else if (enc_en) begin
                en_count++;
                chk_b("en_while_done", enc_done, 1'b0);
                if (exp_iss_q.size() == 0) fail_now("unexpected_enc_en");
                else chk("enc_data_order", 256'(enc_data), 256'(exp_iss_q.pop_front()));
                m_data = enc_data;
                m_cnt  = m_hang ? 0 : m_dly;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    enc_done   = 1'b1;
                    enc_result = enc_f(m_data);
                    m_hcnt     = m_hold;
                end
            end else if (enc_done) begin
                m_hcnt--;
                if (m_hcnt <= 0) begin
                    enc_done   = 1'b0;
                    enc_result = '0;
                end
            end
        end
    end

    // Output monitor: scoreboard pop, stall stability, no acceptance while busy
    logic [NW*CW-1:0] prev_data;
    bit               prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (busy) chk_b("in_ready_while_busy", in_ready, 1'b0);
            if (prev_stall) begin
                chk_b("out_valid_held", out_valid, 1'b1);
                chk("out_data_held", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_out_q.size() == 0) fail_now("unexpected_output");
                else chk("out_block", out_data, exp_out_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(input logic [NW*WW-1:0] d, input logic [NW*CW-1:0] exp, input bit keep);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 3000) begin
                fail_now("send_timeout");
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        exp_out_q.push_back(exp);
        for (int i = 0; i < NW; i++) exp_iss_q.push_back(d[i*WW +: WW]);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_out_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                fail_now("drain_timeout");
                exp_out_q.delete();
                return;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk_b({tag, "_in_ready"},  in_ready,  1'b1);
        chk_b({tag, "_enc_en"},    enc_en,    1'b0);
        chk({tag, "_enc_data"},    256'(enc_data), '0);
        chk_b({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"},    out_data,  '0);
        chk_b({tag, "_busy"},      busy,      1'b0);
        chk_b({tag, "_err"},       err,       1'b0);
    endtask

    typedef struct {
        logic [NW*WW-1:0] data;
        int               dly;
        int               hold;
        int               stall;
        logic [NW*CW-1:0] exp;
    } vec_t;

    vec_t tv[5];

    initial begin
        int n0;
        int n;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        tv[0] = '{128'h0000_0000_0000_0005_0000_0000_0000_0003, 10, 1, 0, '0};
        tv[1] = '{128'h0, 1, 1, 0, '0};
        tv[2] = '{{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF}, 3, 4, 0, '0};
        tv[3] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 2, 4, 7, '0};
        tv[4] = '{128'h8000_0000_0000_0001_7FFF_FFFF_FFFF_FFFE, 5, 2, 3, '0};
        for (int i = 0; i < 5; i++) tv[i].exp = pack_exp(tv[i].data);

        repeat (3) @(posedge clk); #1;
        chk_reset_values("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // table-driven blocks
        for (int i = 0; i < 5; i++) begin
            m_dly = tv[i].dly; m_hold = tv[i].hold;
            out_ready = (tv[i].stall == 0);
            n0 = en_count;
            send(tv[i].data, tv[i].exp, 1'b0);
            if (i == 0) begin
                @(negedge clk); chk_b("latency_issue_no_en", enc_en, 1'b0);
                @(negedge clk); chk_b("latency_first_en", enc_en, 1'b1);
            end
            if (tv[i].stall > 0) begin
                n = 0;
                while (!out_valid && n < 2000) begin @(negedge clk); n++; end
                if (!out_valid) fail_now("stall_wait_valid");
                repeat (tv[i].stall) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            wait_drain(2000);
            chk("en_pulses", 256'(en_count - n0), 256'(NW));
        end

        // long output stall with a competing input block
        begin
            logic [NW*WW-1:0] a, c;
            a = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
            c = 128'h0C0C_0C0C_0C0C_0C0C_C0C0_C0C0_C0C0_C0C0;
            m_dly = 2; m_hold = 1; out_ready = 1'b0;
            send(a, pack_exp(a), 1'b0);
            n = 0;
            while (!out_valid && n < 2000) begin @(negedge clk); n++; end
            if (!out_valid) fail_now("stall20_wait_valid");
            @(posedge clk); #1;
            in_data = c; in_valid = 1'b1;
            repeat (20) begin @(negedge clk); chk_b("stall_in_ready", in_ready, 1'b0); end
            @(posedge clk); #1 out_ready = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            chk_b("in_ready_after_accept", in_ready, 1'b1);
            chk_b("out_valid_after_accept", out_valid, 1'b0);
            @(posedge clk); #1;
            exp_out_q.push_back(pack_exp(c));
            for (int i = 0; i < NW; i++) exp_iss_q.push_back(c[i*WW +: WW]);
            in_valid = 1'b0;
            wait_drain(2000);
        end

        // back-to-back blocks with in_valid held high
        begin
            logic [NW*WW-1:0] b1, b2;
            b1 = 128'h1111_1111_1111_1111_2222_2222_2222_2222;
            b2 = 128'h3333_3333_3333_3333_4444_4444_4444_4444;
            m_dly = 1; m_hold = 1;
            n0 = en_count;
            send(b1, pack_exp(b1), 1'b1);
            send(b2, pack_exp(b2), 1'b0);
            wait_drain(2000);
            chk("b2b_en_pulses", 256'(en_count - n0), 256'(2 * NW));
        end

        // asynchronous reset during WAIT_DONE of word 1
        begin
            logic [NW*WW-1:0] r, r2;
            r  = 128'h5555_5555_5555_5555_6666_6666_6666_6666;
            r2 = 128'h7777_7777_7777_7777_8888_8888_8888_8888;
            m_dly = 10; m_hold = 1;
            n0 = en_count;
            send(r, pack_exp(r), 1'b0);
            n = 0;
            while (en_count < n0 + 2 && n < 2000) begin @(negedge clk); n++; end
            if (en_count < n0 + 2) fail_now("wait_word1_en");
            repeat (3) @(negedge clk);
            #2 rst = 1'b0;
            #1 chk_reset_values("midblock_reset");
            exp_out_q.delete();
            exp_iss_q.delete();
            @(posedge clk); @(posedge clk); #1 rst = 1'b1;
            n0 = en_count;
            send(r2, pack_exp(r2), 1'b0);
            wait_drain(2000);
            chk("post_reset_en_pulses", 256'(en_count - n0), 256'(NW));
        end

        // hung encoder
        begin
            logic [NW*WW-1:0] h;
            h = 128'h9999_9999_9999_9999_AAAA_AAAA_AAAA_AAAA;
            m_hang = 1'b1;
`ifdef SCHED_TIMEOUT_EN
            send(h, '1, 1'b0);
            wait_drain(2000);
            chk_b("timeout_err", err, 1'b1);
            m_hang = 1'b0; m_dly = 2;
            send(tv[0].data, tv[0].exp, 1'b0);
            wait_drain(2000);
            chk_b("err_sticky", err, 1'b1);
`else
            send(h, pack_exp(h), 1'b0);
            repeat (200) @(negedge clk);
            chk_b("hang_busy", busy, 1'b1);
            chk_b("hang_no_output", out_valid, 1'b0);
            chk_b("hang_no_err", err, 1'b0);
`endif
            #2 rst = 1'b0;
            #1 chk_reset_values("final_reset");
            exp_out_q.delete();
            exp_iss_q.delete();
            m_hang = 1'b0;
            @(posedge clk); #1 rst = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
